// File: rtl/systolic_pe.sv
// systolic_pe: signed MAC PE; A/B forwarded east/south with 1-cycle latency, result valid 1 cycle after the last beat.
// No backpressure; i_enable=0 freezes every register. Define SYSTOLIC_PE_RELU_EN to clamp negative results to 0.
module systolic_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_valid,
  input  logic                  i_last,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic                  o_valid_fwd,
  output logic                  o_last_fwd,
  output logic [OUT_WIDTH-1:0]  o_result,
  output logic                  o_result_valid,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  vld_fwd_q, vld_fwd_d, last_fwd_q, last_fwd_d;
  logic [0:0]            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0]  result_q, result_d;
  logic                  result_vld_q, result_vld_d;
  logic                  overflow_q, overflow_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext, acc_eff, sum_sat, sum_shift, res_wide;
  logic signed [ACC_WIDTH:0]      sum_wide;
  logic                           add_sat, ovf_eff, out_sat;
  logic [OUT_WIDTH-1:0]           res_out;

  // Finish-time datapath: saturating add, arithmetic shift, output saturation.
  always_comb begin
    prod     = $signed({{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a}) *
               $signed({{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b});
    prod_ext = ACC_WIDTH'(prod);
    acc_eff  = (state_q == ST_ACCUM) ? $signed(acc_q) : '0;
    sum_wide = {acc_eff[ACC_WIDTH-1], acc_eff} + {prod_ext[ACC_WIDTH-1], prod_ext};
    add_sat  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    if (add_sat) begin
      sum_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_sat = sum_wide[ACC_WIDTH-1:0];
    end
    ovf_eff   = ((state_q == ST_ACCUM) & ovf_q) | add_sat;
    sum_shift = sum_sat >>> OUT_SHIFT;
    out_sat   = 1'b0;
    res_wide  = sum_shift;
    if (sum_shift > OUT_MAX) begin
      res_wide = OUT_MAX;
      out_sat  = 1'b1;
    end else if (sum_shift < OUT_MIN) begin
      res_wide = OUT_MIN;
      out_sat  = 1'b1;
    end
    res_out = res_wide[OUT_WIDTH-1:0];
`ifdef SYSTOLIC_PE_RELU_EN
    if (res_out[OUT_WIDTH-1]) begin
      res_out = '0;
    end
`else
`endif
  end

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    vld_fwd_d    = vld_fwd_q;
    last_fwd_d   = last_fwd_q;
    state_d      = state_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    result_d     = result_q;
    result_vld_d = result_vld_q;
    overflow_d   = overflow_q;
    if (i_enable) begin
      a_d          = i_a;
      b_d          = i_b;
      vld_fwd_d    = i_valid;
      last_fwd_d   = i_last & i_valid;
      result_vld_d = 1'b0;
      if (i_clear) begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        state_d = ST_IDLE;
      end else if (i_valid) begin
        if (i_last) begin
          result_d     = res_out;
          overflow_d   = ovf_eff | out_sat;
          result_vld_d = 1'b1;
          acc_d        = '0;
          ovf_d        = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          acc_d   = sum_sat;
          ovf_d   = ovf_eff;
          state_d = ST_ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      a_q          <= '0;
      b_q          <= '0;
      vld_fwd_q    <= 1'b0;
      last_fwd_q   <= 1'b0;
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      vld_fwd_q    <= vld_fwd_d;
      last_fwd_q   <= last_fwd_d;
      state_q      <= state_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_a            = a_q;
  assign o_b            = b_q;
  assign o_valid_fwd    = vld_fwd_q;
  assign o_last_fwd     = last_fwd_q;
  assign o_result       = result_q;
  assign o_result_valid = result_vld_q;
  assign o_overflow     = overflow_q;
  assign o_busy         = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: integer reference model checked every cycle, plus directed literal checks.
module tb_systolic_pe;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int OW = 16;
  localparam int SH = 0;
  localparam longint ACC_MAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint ACC_MIN = -ACC_MAX - 1;
  localparam longint OUT_MAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint OUT_MIN = -OUT_MAX - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset, i_enable, i_valid, i_last, i_clear;
  logic [DW-1:0] i_a, i_b;
  logic [DW-1:0] o_a, o_b, s2_a, s2_b;
  logic          o_valid_fwd, o_last_fwd, o_result_valid, o_overflow, o_busy;
  logic          s2_vf, s2_lf, s2_rv, s2_ovf, s2_busy;
  logic [OW-1:0] o_result, s2_result;

  systolic_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .OUT_SHIFT(SH)) u_dut (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_a(i_a), .i_b(i_b),
    .i_valid(i_valid), .i_last(i_last), .i_clear(i_clear),
    .o_a(o_a), .o_b(o_b), .o_valid_fwd(o_valid_fwd), .o_last_fwd(o_last_fwd),
    .o_result(o_result), .o_result_valid(o_result_valid), .o_overflow(o_overflow),
    .o_busy(o_busy));

  systolic_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .OUT_SHIFT(2)) u_dut_s2 (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_a(i_a), .i_b(i_b),
    .i_valid(i_valid), .i_last(i_last), .i_clear(i_clear),
    .o_a(s2_a), .o_b(s2_b), .o_valid_fwd(s2_vf), .o_last_fwd(s2_lf),
    .o_result(s2_result), .o_result_valid(s2_rv), .o_overflow(s2_ovf),
    .o_busy(s2_busy));

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the running dot product as a plain integer sum.
  longint  m_acc, p, s, e_res;
  bit      m_ovf, m_in, so;
  logic [DW-1:0] e_a, e_b;
  bit      e_vf, e_lf, e_rv, e_ovf, e_busy;

  always @(posedge clk) begin
    if (!i_reset) begin
      m_acc = 0; m_ovf = 0; m_in = 0;
      e_a = '0; e_b = '0; e_vf = 0; e_lf = 0; e_res = 0; e_rv = 0; e_ovf = 0; e_busy = 0;
    end else if (i_enable) begin
      e_a = i_a; e_b = i_b; e_vf = i_valid; e_lf = i_valid & i_last; e_rv = 0;
      if (i_clear) begin
        m_acc = 0; m_ovf = 0; m_in = 0;
      end else if (i_valid) begin
        p  = longint'($signed(i_a)) * longint'($signed(i_b));
        s  = (m_in ? m_acc : 0) + p;
        so = m_in & m_ovf;
        if (s > ACC_MAX) begin s = ACC_MAX; so = 1; end
        else if (s < ACC_MIN) begin s = ACC_MIN; so = 1; end
        if (i_last) begin
          s = s >>> SH;
          if (s > OUT_MAX) begin s = OUT_MAX; so = 1; end
          else if (s < OUT_MIN) begin s = OUT_MIN; so = 1; end
`ifdef SYSTOLIC_PE_RELU_EN
          if (s < 0) s = 0;
`else
`endif
          e_res = s; e_ovf = so; e_rv = 1;
          m_acc = 0; m_ovf = 0; m_in = 0;
        end else begin
          m_acc = s; m_ovf = so; m_in = 1;
        end
      end
      e_busy = m_in;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_o_a", longint'(o_a), longint'(e_a));
      chk("m_o_b", longint'(o_b), longint'(e_b));
      chk("m_valid_fwd", longint'(o_valid_fwd), longint'(e_vf));
      chk("m_last_fwd", longint'(o_last_fwd), longint'(e_lf));
      chk("m_result", longint'($signed(o_result)), e_res);
      chk("m_result_valid", longint'(o_result_valid), longint'(e_rv));
      chk("m_overflow", longint'(o_overflow), longint'(e_ovf));
      chk("m_busy", longint'(o_busy), longint'(e_busy));
    end
  end

  task automatic beat(input int a, input int b, input bit v, input bit l, input bit c);
    i_a = DW'(a); i_b = DW'(b); i_valid = v; i_last = l; i_clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    i_a = DW'($urandom); i_b = DW'($urandom);
    i_valid = 1'($urandom); i_last = 1'($urandom); i_clear = 1'($urandom);
  endtask

  initial begin
    i_reset = 1'b0; i_enable = 1'b1;
    rand_inputs();
    @(posedge clk);
    #1;
    chk("rst_o_a", longint'(o_a), 0);
    chk("rst_o_b", longint'(o_b), 0);
    chk("rst_valid_fwd", longint'(o_valid_fwd), 0);
    chk("rst_result", longint'(o_result), 0);
    chk("rst_result_valid", longint'(o_result_valid), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk_on = 1'b1;

    i_reset = 1'b1; i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      @(posedge clk);
      #1;
      chk("hold_o_a", longint'(o_a), 0);
      chk("hold_result_valid", longint'(o_result_valid), 0);
    end
    i_enable = 1'b1;

    beat(3, 4, 1, 0, 0);
    chk("fwd_a", longint'($signed(o_a)), 3);
    beat(-2, 5, 1, 0, 0);
    chk("fwd_a_neg", longint'($signed(o_a)), -2);
    chk("busy_accum", longint'(o_busy), 1);
    beat(7, 7, 1, 1, 0);
    chk("dot_result", longint'($signed(o_result)), 51);
    chk("dot_valid", longint'(o_result_valid), 1);
    chk("dot_ovf", longint'(o_overflow), 0);
    beat(0, 0, 0, 0, 0);
    chk("dot_pulse_end", longint'(o_result_valid), 0);
    chk("dot_hold", longint'($signed(o_result)), 51);

    for (int i = 0; i < 4; i++) beat(127, 127, 1, i == 3, 0);
    chk("sat_pos_result", longint'($signed(o_result)), 32767);
    chk("sat_pos_ovf", longint'(o_overflow), 1);
    chk("shift2_result", longint'($signed(s2_result)), 16129);
    chk("shift2_ovf", longint'(s2_ovf), 0);
    for (int i = 0; i < 3; i++) beat(-128, 127, 1, i == 2, 0);
    chk("sat_neg_result", longint'($signed(o_result)), -32768);
    chk("sat_neg_ovf", longint'(o_overflow), 1);

    beat(5, 5, 1, 0, 0);
    beat(1, 1, 1, 1, 0);
    chk("b2b_first", longint'($signed(o_result)), 26);
    chk("b2b_first_valid", longint'(o_result_valid), 1);
    beat(2, 3, 1, 1, 0);
    chk("b2b_second", longint'($signed(o_result)), 6);
    chk("b2b_second_valid", longint'(o_result_valid), 1);
    beat(0, 0, 0, 0, 0);
    chk("b2b_bubble_valid", longint'(o_result_valid), 0);

    beat(10, 10, 1, 0, 0);
    beat(10, 10, 1, 0, 0);
    beat(9, 9, 1, 0, 1);
    chk("clr_valid_fwd", longint'(o_valid_fwd), 1);
    chk("clr_busy", longint'(o_busy), 0);
    beat(1, 1, 1, 1, 0);
    chk("clr_result", longint'($signed(o_result)), 1);

    beat(2, 3, 1, 0, 0);
    beat(4, 5, 1, 0, 0);
    i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      @(posedge clk);
      #1;
      chk("stall_busy", longint'(o_busy), 1);
      chk("stall_o_a", longint'(o_a), 4);
    end
    i_enable = 1'b1;
    beat(1, 1, 1, 1, 0);
    chk("stall_result", longint'($signed(o_result)), 27);
    beat(-3, 4, 1, 1, 0);
`ifdef SYSTOLIC_PE_RELU_EN
    chk("relu_result", longint'($signed(o_result)), 0);
`else
    chk("signed_result", longint'($signed(o_result)), -12);
`endif

    for (int i = 0; i < 3000; i++) begin
      i_reset  = ($urandom_range(0, 199) != 0);
      i_enable = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: i_a = 8'h7f;
        1: i_a = 8'h80;
        default: i_a = DW'($urandom);
      endcase
      i_b     = ($urandom_range(0, 3) == 0) ? 8'h80 : DW'($urandom);
      i_valid = ($urandom_range(0, 9) < 7);
      i_last  = ($urandom_range(0, 3) == 0);
      i_clear = ($urandom_range(0, 32) == 0);
      @(posedge clk);
      #1;
    end

    i_valid = 1'b0; i_reset = 1'b1; i_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
- Parametrised multiply-accumulate processing element, the successor to the basic PE.
- Tiles into a 2-D systolic array for CNN convolution and matrix multiply.
- Forwards operands east (A) and south (B) through registers.
- Accumulates a signed dot product framed by valid/last, then emits one shifted, saturated result per dot product with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 8, width of signed operands A and B
ACC_WIDTH, 32, internal signed accumulator width (must be >= 2*DATA_WIDTH)
OUT_WIDTH, 16, signed result width (must be <= ACC_WIDTH)
OUT_SHIFT, 0, arithmetic right shift applied to final sum before output saturation (0..ACC_WIDTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous reset, active-low
i_enable  in  1  global advance; low = entire PE holds state, including forwarding regs
i_a  in  DATA_WIDTH  signed operand from west
i_b  in  DATA_WIDTH  signed operand from north
i_valid  in  1  i_a/i_b pair is a valid beat
i_last  in  1  qualifies i_valid; final beat of current dot product
i_clear  in  1  abort accumulation, zero accumulator
o_a  out  DATA_WIDTH  registered i_a to east neighbour
o_b  out  DATA_WIDTH  registered i_b to south neighbour
o_valid_fwd  out  1  registered i_valid
o_last_fwd  out  1  registered i_last & i_valid
o_result  out  OUT_WIDTH  saturated dot-product result
o_result_valid  out  1  one-cycle pulse: o_result/o_overflow updated
o_overflow  out  1  saturation occurred in the dot product now on o_result
o_busy  out  1  high in ACCUM state

Behaviour:
- Reset (i_reset=0 at edge): all outputs and accumulator 0, state IDLE. Takes priority over i_enable.
- i_enable=0: no register changes; outputs hold. o_result_valid holds its value, so the bench sees no new pulse.
- Forwarding (enable=1): o_a, o_b, o_valid_fwd, o_last_fwd load from inputs every cycle, independent of FSM and i_clear. Latency 1 cycle per hop.
- Product: full-precision signed DATA_WIDTH x DATA_WIDTH, sign-extended to ACC_WIDTH.
- Accumulator add saturates at ACC_WIDTH signed limits. Hitting a limit sets an internal sticky ovf flag.
- FSM states: IDLE, ACCUM.
  - IDLE: on i_valid & ~i_last, acc <= product and go to ACCUM. On i_valid & i_last, single-beat result, stay IDLE.
  - ACCUM: on i_valid & ~i_last, acc <= sat(acc+product). On i_valid & i_last, finish and go to IDLE.
  - i_valid=0: hold (bubbles allowed).
- Finish (edge sampling the last beat):
  - sum = sat(acc+product), where acc is treated as 0 when finishing from IDLE.
  - o_result <= sat_OUT(sum >>> OUT_SHIFT).
  - o_overflow <= ovf | output-saturation.
  - o_result_valid <= 1; acc and ovf cleared.
  - Latency: result visible the cycle after the last beat.
- o_result_valid deasserts the next enabled cycle unless another finish occurs. Back-to-back finishes give consecutive pulses.
- o_result and o_overflow hold until the next finish.
- i_clear=1 (enable=1): acc<=0, ovf<=0, state IDLE. A beat presented the same cycle is discarded (still forwarded). o_result, o_overflow and o_result_valid are unaffected by the clear itself, except that valid still drops per the pulse rule.
- Negative shift results round toward minus infinity (arithmetic shift).

Optional Feature:
Macro SYSTOLIC_PE_RELU_EN.
- Defined: at finish, a negative saturated output is replaced by 0 before registering o_result. o_overflow is unchanged by the clamp.
- Undefined: signed result passes through unmodified.

Test Plan:
Defaults, macro undefined.
1. Reset: drive i_reset=0 one edge with random inputs -> all outputs 0, o_busy=0. After release with i_enable=0, nothing changes.
2. Dot product: beats (3,4),(-2,5),(7,7,last) on consecutive cycles -> one cycle after the last beat o_result=51, o_result_valid=1 for exactly one cycle, o_overflow=0. o_a/o_b equal i_a/i_b delayed by one cycle throughout.
3. Saturation: four beats (127,127) with last on the fourth (sum 64516) -> o_result=32767, o_overflow=1. Three beats (-128,127) (sum -48768) -> o_result=-32768, o_overflow=1. With OUT_SHIFT=2 and the first case -> o_result=16129, o_overflow=0.
4. Back-to-back with bubble: (5,5),(1,1,last) immediately followed by (2,3,last), then bubble -> pulses on consecutive cycles with results 26 then 6.
5. Clear mid-stream: (10,10),(10,10), then i_clear with (9,9) valid, then (1,1,last) -> o_result=1. o_valid_fwd shows the discarded beat.
6. Stall: hold i_enable=0 for 3 cycles in ACCUM while toggling inputs -> all outputs frozen. Resume -> result matches the unstalled sum. With SYSTOLIC_PE_RELU_EN, (-3,4,last) -> o_result=0.
